rs_tx_framer: RTL and testbench

RS_TX_FRAMER -- requirements
Module: rs_tx_framer

---
 rtl/rs_tx_framer.sv | 141 ++++++++++++++
 tb/tb_rs_tx_framer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rs_tx_framer.sv
// UART-style serial transmit framer: one byte per frame, start bit, 8 data bits
// LSB first, optional even parity, one stop bit; every bit lasts N1+1 clocks.
module rs_tx_framer #(
  parameter int N1        = 10417,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [13:0] N1_TERM = N1[13:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_r;
  logic [13:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
  logic        par_r;
  logic        ready_r;
  logic        txd_r;
  logic        busy_r;
  logic        done_r;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  assign tx_ready = ready_r;
  assign txd      = txd_r;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;

  // Frame sequencer; txd is driven one state ahead so the line changes on the bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 14'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      par_r   <= 1'b0;
      ready_r <= 1'b1;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 14'd0;
          idx_r <= 3'd0;
          if (tx_valid && ready_r) begin
            shift_r <= tx_data;
            par_r   <= even_parity(tx_data);
            state_r <= START;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            txd_r   <= 1'b0;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            txd_r   <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == N1_TERM) begin
            cnt_r   <= 14'd0;
            idx_r   <= 3'd0;
            state_r <= DATA;
            txd_r   <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end
        DATA: begin
          if (cnt_r == N1_TERM) begin
            cnt_r   <= 14'd0;
            shift_r <= shift_r >> 1;
            if (idx_r == 3'd7) begin
              idx_r <= 3'd0;
              if (PARITY_EN) begin
                state_r <= PARITY;
                txd_r   <= par_r;
              end else begin
                state_r <= STOP;
                txd_r   <= 1'b1;
              end
            end else begin
              idx_r <= idx_r + 3'd1;
              txd_r <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end
        PARITY: begin
          if (cnt_r == N1_TERM) begin
            cnt_r   <= 14'd0;
            state_r <= STOP;
            txd_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end
        STOP: begin
          if (cnt_r == N1_TERM) begin
            cnt_r   <= 14'd0;
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            txd_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 14'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 14'd0;
          idx_r   <= 3'd0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          txd_r   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_tx_framer.sv
// Directed bench for rs_tx_framer with N1=3 (4 clocks per bit), one 8N1 and one 8E1 instance.
module tb_rs_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_n = 8'h00, data_p = 8'h00;
  logic       valid_n = 1'b0, valid_p = 1'b0;
  logic       ready_n, txd_n, busy_n, done_n;
  logic       ready_p, txd_p, busy_p, done_p;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  rs_tx_framer #(.N1(3), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .tx_data(data_n), .tx_valid(valid_n),
    .tx_ready(ready_n), .txd(txd_n), .tx_busy(busy_n), .tx_done(done_n)
  );

  rs_tx_framer #(.N1(3), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .tx_data(data_p), .tx_valid(valid_p),
    .tx_ready(ready_p), .txd(txd_p), .tx_busy(busy_p), .tx_done(done_p)
  );

  typedef struct {
    logic       sel;   // 0: 8N1 instance, 1: 8E1 instance
    logic [7:0] data;
    string      bits;  // expected line levels in transmit order
  } vec_t;

  vec_t vecs[7];

  // {txd, tx_busy, tx_ready, tx_done}
  function automatic logic [3:0] outs(input logic sel);
    return sel ? {txd_p, busy_p, ready_p, done_p} : {txd_n, busy_n, ready_n, done_n};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got txd/busy/ready/done=%b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [7:0] d);
    if (sel) begin
      valid_p = v; data_p = d;
    end else begin
      valid_n = v; data_n = d;
    end
  endtask

  // Returns #1 after the accept edge; a missing accept counts as a failure.
  task automatic wait_accept(input logic sel);
    for (int i = 0; i < 200; i++) begin
      if (outs(sel) == 4'b1010) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_bad++;
    $display("FAIL accept_timeout: got no ready within 200 cycles want ready");
  endtask

  // Checks every cycle of the frame plus the tx_done cycle that follows it.
  task automatic check_frame(input logic sel, input string exp, input string tag);
    for (int i = 0; i < exp.len(); i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("%s bit%0d cyc%0d", tag, i, c), outs(sel),
              {(exp[i] == "1"), 1'b1, 1'b0, 1'b0});
      end
    end
    @(negedge clk);
    check({tag, " done_cycle"}, outs(sel), 4'b1011);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'hA5, "0101001011"};
    vecs[1] = '{1'b0, 8'h3C, "0001111001"};
    vecs[2] = '{1'b0, 8'h00, "0000000001"};
    vecs[3] = '{1'b0, 8'hFF, "0111111111"};
    vecs[4] = '{1'b1, 8'h07, "01110000011"};
    vecs[5] = '{1'b1, 8'h03, "01100000001"};
    vecs[6] = '{1'b1, 8'h80, "00000000111"};

    // Accept requests during reset must be discarded.
    rst = 1'b1; drive(1'b0, 1'b1, 8'hFF); drive(1'b1, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; drive(1'b0, 1'b0, 8'h00); drive(1'b1, 1'b0, 8'h00);
    check("reset_n", outs(1'b0), 4'b1010);
    check("reset_p", outs(1'b1), 4'b1010);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_line", outs(1'b0), 4'b1010);
    end
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].sel, 1'b1, vecs[v].data);
      wait_accept(vecs[v].sel);
      drive(vecs[v].sel, 1'b0, 8'h00);
      check_frame(vecs[v].sel, vecs[v].bits, $sformatf("vec%0d", v));
      @(posedge clk); #1;
      check($sformatf("vec%0d done_low", v), outs(vecs[v].sel), 4'b1010);
    end

    // Back-to-back with tx_valid held high: one idle-high cycle between frames.
    drive(1'b0, 1'b1, 8'h00);
    wait_accept(1'b0);
    drive(1'b0, 1'b1, 8'hFF);
    check_frame(1'b0, "0000000001", "b2b0");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, "0111111111", "b2b1");
    @(posedge clk); #1;
    check("b2b done_low", outs(1'b0), 4'b1010);

    // New data and a valid pulse mid-frame must be ignored.
    drive(1'b0, 1'b1, 8'h3C);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, 8'h3C);
    fork
      check_frame(1'b0, "0001111001", "busy");
      begin
        repeat (10) @(posedge clk);
        #1 drive(1'b0, 1'b1, 8'h55);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 8'hAA);
      end
    join
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy no_extra_accept", outs(1'b0), 4'b1010);
    end
    @(posedge clk); #1;

    // Reset during data bit 3 of 0xA5 (a zero bit).
    drive(1'b0, 1'b1, 8'hA5);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, 8'h00);
    repeat (16) @(posedge clk);
    #1;
    check("pre_rst bit3", outs(1'b0), 4'b0100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst", outs(1'b0), 4'b1010);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("post_rst no_done", outs(1'b0), 4'b1010);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hA5);
    wait_accept(1'b0);
    drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, "0101001011", "after_rst");
    @(posedge clk); #1;
    check("after_rst done_low", outs(1'b0), 4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
